// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// A beat is two packed RV64 instructions plus the PC of the low word.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int BEAT_W  = 64;
    localparam int PC_W    = 64;

    localparam logic [INSTR_W-1:0] INSTR_NOP  = 32'h0000_0013;
    localparam logic [INSTR_W-1:0] INSTR_HALT = 32'h0000_0000;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [BEAT_W-1:0] data;
    } fetch_beat_t;

    function automatic logic [INSTR_W-1:0] beat_word(input logic [BEAT_W-1:0] d, input logic hi);
        return hi ? d[BEAT_W-1:INSTR_W] : d[INSTR_W-1:0];
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-side beat bus, decode-side instruction bus and redirect/status lines.
// master = fetch/decode/redirect environment, slave = the queue.
interface fetch_queue_if #(
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 64
);
    import fetch_pkg::*;

    logic                    beat_valid;
    logic                    beat_ready;
    logic [BEAT_W-1:0]       beat_data;
    logic [ADDR_WIDTH-1:0]   beat_pc;
    logic                    instr_valid;
    logic                    instr_ready;
    logic [INSTR_W-1:0]      instr;
    logic [ADDR_WIDTH-1:0]   instr_pc;
    logic                    flush;
    logic [ADDR_WIDTH-1:0]   flush_pc;
    logic                    halted;
    logic [$clog2(DEPTH):0]  level;

    modport master (
        output beat_valid, beat_data, beat_pc, instr_ready, flush, flush_pc,
        input  beat_ready, instr_valid, instr, instr_pc, halted, level
    );

    modport slave (
        input  beat_valid, beat_data, beat_pc, instr_ready, flush, flush_pc,
        output beat_ready, instr_valid, instr, instr_pc, halted, level
    );

endinterface

// File: rtl/fetch_queue_beat_fifo.sv
// Circular buffer of DEPTH fetch beats with push/pop/clear and an occupancy count.
// The caller never pushes when full nor pops when empty.
module beat_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  fetch_beat_t            wdata_i,
    input  logic                   pop_i,
    input  logic                   clear_i,
    output fetch_beat_t            head_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PW = $clog2(DEPTH);

    fetch_beat_t    mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW:0]    count_q, count_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + (PW+1)'(1);
                2'b01:   count_d = count_q - (PW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling queue: 64-bit beats in, one 32-bit instruction per cycle out.
// Define FETCH_QUEUE_TRACE_EN for a simulation-only dequeue/halt trace.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 64
) (
    input logic          clk,
    input logic          reset,
    fetch_queue_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_beat_t            head;
    fetch_beat_t            wbeat;
    logic [CW-1:0]          count;
    logic                   push, deq, pop;
    logic                   nonempty, head_zero;
    logic [INSTR_W-1:0]     head_word;
    logic [ADDR_WIDTH-1:0]  head_pc;
    logic                   half_q, half_d;
    logic                   skip_lo_q, skip_lo_d;
    logic                   halted_q, halted_d;

    assign wbeat = '{pc: PC_W'(bus.beat_pc), data: bus.beat_data};

    beat_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .wdata_i (wbeat),
        .pop_i   (pop),
        .clear_i (bus.flush),
        .head_o  (head),
        .count_o (count)
    );

    assign nonempty  = (count != '0);
    assign head_word = beat_word(head.data, half_q);
    assign head_pc   = ADDR_WIDTH'(head.pc) + (half_q ? ADDR_WIDTH'(4) : '0);
    assign head_zero = nonempty && (head_word == INSTR_HALT);

    // Head is forced to zero when empty so storage contents never leak out.
    assign bus.instr       = nonempty ? head_word : '0;
    assign bus.instr_pc    = nonempty ? head_pc   : '0;
    assign bus.instr_valid = nonempty && !halted_q && !bus.flush && !head_zero;
    assign bus.beat_ready  = (count != CW'(DEPTH)) && !bus.flush && !halted_q;
    assign bus.halted      = halted_q;
    assign bus.level       = count;

    assign push = bus.beat_valid && bus.beat_ready;
    assign deq  = bus.instr_valid && bus.instr_ready;
    assign pop  = deq && half_q;

    // A skipped low word can only apply to the first beat after a flush, which
    // lands in an empty queue, so it can never collide with a dequeue.
    always_comb begin
        half_d    = half_q;
        skip_lo_d = skip_lo_q;
        halted_d  = halted_q;
        if (bus.flush) begin
            half_d    = 1'b0;
            skip_lo_d = bus.flush_pc[2];
            halted_d  = 1'b0;
        end else begin
            if (deq) half_d = !half_q;
            if (push && skip_lo_q) begin
                half_d    = 1'b1;
                skip_lo_d = 1'b0;
            end
            if (head_zero) halted_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            half_q    <= 1'b0;
            skip_lo_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            half_q    <= half_d;
            skip_lo_q <= skip_lo_d;
            halted_q  <= halted_d;
        end
    end

`ifdef FETCH_QUEUE_TRACE_EN
    always_ff @(posedge clk) begin
        if (reset && deq) $display("%h: %h", bus.instr_pc, bus.instr);
        if (reset && halted_d && !halted_q) $display("fetch_queue halted at %h", head_pc);
    end
`else
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed table, corner sequences, random vs. word-level model.
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int DEPTH = 8;
    localparam int AW    = 64;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fetch_queue_if #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) bus ();
    fetch_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic        bv;
        logic [63:0] data;
        logic [63:0] pc;
        logic        ir;
        logic        fl;
        logic [63:0] fpc;
        logic        iv;
        logic [31:0] ins;
        logic [63:0] ipc;
        logic        br;
        logic [LW-1:0] lvl;
        logic        h;
    } vec_t;

    typedef struct {
        logic [31:0] w;
        logic [63:0] pc;
        bit          last;
    } mword_t;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_out(input string t, input logic iv, input logic [31:0] ins, input logic [63:0] ipc,
                           input logic br, input logic [LW-1:0] lvl, input logic h);
        chk({t, ".instr_valid"}, 128'(bus.instr_valid), 128'(iv));
        chk({t, ".instr"},       128'(bus.instr),       128'(ins));
        chk({t, ".instr_pc"},    128'(bus.instr_pc),    128'(ipc));
        chk({t, ".beat_ready"},  128'(bus.beat_ready),  128'(br));
        chk({t, ".level"},       128'(bus.level),       128'(lvl));
        chk({t, ".halted"},      128'(bus.halted),      128'(h));
    endtask

    task automatic drive(input logic bv, input logic [63:0] d, input logic [63:0] pc,
                         input logic ir, input logic fl, input logic [63:0] fpc);
        bus.beat_valid  = bv;
        bus.beat_data   = d;
        bus.beat_pc     = pc;
        bus.instr_ready = ir;
        bus.flush       = fl;
        bus.flush_pc    = fpc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beats(input int n, input logic [63:0] base);
        for (int k = 0; k < n; k++) begin
            drive(1'b1, {32'h100 + 32'(k), 32'h200 + 32'(k)}, base + 64'(8 * k), 1'b0, 1'b0, 64'h0);
            tick();
        end
        drive(1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0);
    endtask

    vec_t   vt [13];
    mword_t mq [$];
    bit     m_halt, m_skip;

    initial begin
        vt[0]  = '{1'b1, 64'h00a00593_00000513, 64'h1000, 1'b1, 1'b0, 64'h0,    1'b0, 32'h0,        64'h0,    1'b1, 4'd0, 1'b0};
        vt[1]  = '{1'b0, 64'h0,                 64'h0,    1'b1, 1'b0, 64'h0,    1'b1, 32'h00000513, 64'h1000, 1'b1, 4'd1, 1'b0};
        vt[2]  = '{1'b0, 64'h0,                 64'h0,    1'b1, 1'b0, 64'h0,    1'b1, 32'h00a00593, 64'h1004, 1'b1, 4'd1, 1'b0};
        vt[3]  = '{1'b0, 64'h0,                 64'h0,    1'b1, 1'b1, 64'h2004, 1'b0, 32'h0,        64'h0,    1'b0, 4'd0, 1'b0};
        vt[4]  = '{1'b1, 64'h22222222_11111111, 64'h2000, 1'b1, 1'b0, 64'h0,    1'b0, 32'h0,        64'h0,    1'b1, 4'd0, 1'b0};
        vt[5]  = '{1'b0, 64'h0,                 64'h0,    1'b1, 1'b0, 64'h0,    1'b1, 32'h22222222, 64'h2004, 1'b1, 4'd1, 1'b0};
        vt[6]  = '{1'b0, 64'h0,                 64'h0,    1'b1, 1'b0, 64'h0,    1'b0, 32'h0,        64'h0,    1'b1, 4'd0, 1'b0};
        vt[7]  = '{1'b1, 64'h00000000_00008067, 64'h3000, 1'b1, 1'b0, 64'h0,    1'b0, 32'h0,        64'h0,    1'b1, 4'd0, 1'b0};
        vt[8]  = '{1'b0, 64'h0,                 64'h0,    1'b1, 1'b0, 64'h0,    1'b1, 32'h00008067, 64'h3000, 1'b1, 4'd1, 1'b0};
        vt[9]  = '{1'b0, 64'h0,                 64'h0,    1'b1, 1'b0, 64'h0,    1'b0, 32'h0,        64'h3004, 1'b1, 4'd1, 1'b0};
        vt[10] = '{1'b1, 64'h55555555_55555555, 64'h5000, 1'b1, 1'b0, 64'h0,    1'b0, 32'h0,        64'h3004, 1'b0, 4'd1, 1'b1};
        vt[11] = '{1'b0, 64'h0,                 64'h0,    1'b1, 1'b1, 64'h4000, 1'b0, 32'h0,        64'h3004, 1'b0, 4'd1, 1'b1};
        vt[12] = '{1'b0, 64'h0,                 64'h0,    1'b1, 1'b0, 64'h0,    1'b0, 32'h0,        64'h0,    1'b1, 4'd0, 1'b0};

        // Reset state
        drive(1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0);
        #12;
        chk_out("reset", 1'b0, 32'h0, 64'h0, 1'b1, 4'd0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Directed table: basic delivery, misaligned redirect, halt and flush recovery
        for (int i = 0; i < 13; i++) begin
            drive(vt[i].bv, vt[i].data, vt[i].pc, vt[i].ir, vt[i].fl, vt[i].fpc);
            #2;
            chk_out($sformatf("vec%0d", i), vt[i].iv, vt[i].ins, vt[i].ipc, vt[i].br, vt[i].lvl, vt[i].h);
            tick();
        end

        // Full queue: ninth beat refused, a single-word pop does not free an entry
        push_beats(8, 64'h8000);
        drive(1'b1, 64'h99999999_99999999, 64'h9000, 1'b0, 1'b0, 64'h0);
        #2;
        chk_out("full", 1'b1, 32'h200, 64'h8000, 1'b0, 4'd8, 1'b0);
        tick();
        drive(1'b0, 64'h0, 64'h0, 1'b1, 1'b0, 64'h0);
        #2;
        chk("full.ninth_dropped", 128'(bus.level), 128'(8));
        tick();
        drive(1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0);
        #2;
        chk_out("full.half_pop", 1'b1, 32'h100, 64'h8004, 1'b0, 4'd8, 1'b0);
        drive(1'b0, 64'h0, 64'h0, 1'b1, 1'b0, 64'h0);
        tick();
        drive(1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0);
        #2;
        chk_out("full.entry_pop", 1'b1, 32'h201, 64'h8008, 1'b1, 4'd7, 1'b0);

        // Flush beats a simultaneous push and pop at level 3
        drive(1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 64'h0);
        tick();
        push_beats(3, 64'hA000);
        drive(1'b1, 64'h77777777_66666666, 64'hB000, 1'b1, 1'b1, 64'h0);
        #2;
        chk("flush3.level_before", 128'(bus.level), 128'(3));
        chk("flush3.instr_valid_during", 128'(bus.instr_valid), 128'(0));
        tick();
        drive(1'b0, 64'h0, 64'h0, 1'b1, 1'b0, 64'h0);
        #2;
        chk_out("flush3.after", 1'b0, 32'h0, 64'h0, 1'b1, 4'd0, 1'b0);
        tick();

        // Asynchronous reset in the middle of a burst
        push_beats(5, 64'hC000);
        #2;
        chk("areset.level_before", 128'(bus.level), 128'(5));
        bus.instr_ready = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        chk_out("areset.immediate", 1'b0, 32'h0, 64'h0, 1'b1, 4'd0, 1'b0);
        tick();
        chk_out("areset.held", 1'b0, 32'h0, 64'h0, 1'b1, 4'd0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        bus.instr_ready = 1'b0;
        tick();

        // Random traffic against an instruction-word-level model
        mq.delete();
        m_halt = 1'b0;
        m_skip = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            logic        bv, ir, fl, e_iv, e_br, new_halt;
            logic [31:0] lo, hi, e_ins;
            logic [63:0] bpc, fpc, e_pc;
            int          m_lvl;
            bv  = ($urandom_range(0, 3) != 0);
            ir  = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 24) == 0);
            lo  = ($urandom_range(0, 63) == 0) ? 32'h0 : ($urandom | 32'h1);
            hi  = ($urandom_range(0, 63) == 0) ? 32'h0 : ($urandom | 32'h1);
            bpc = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8 : ({$urandom, $urandom} & ~64'h7);
            fpc = {$urandom, $urandom} & ~64'h3;
            drive(bv, {hi, lo}, bpc, ir, fl, fpc);
            #2;

            m_lvl = 0;
            foreach (mq[k]) if (mq[k].last) m_lvl++;
            e_ins = (mq.size() != 0) ? mq[0].w  : 32'h0;
            e_pc  = (mq.size() != 0) ? mq[0].pc : 64'h0;
            e_iv  = (mq.size() != 0) && !m_halt && !fl && (mq[0].w != 32'h0);
            e_br  = (m_lvl != DEPTH) && !fl && !m_halt;
            chk_out($sformatf("rand%0d", c), e_iv, e_ins, e_pc, e_br, LW'(m_lvl), m_halt);

            if (fl) begin
                mq.delete();
                m_halt = 1'b0;
                m_skip = fpc[2];
            end else begin
                new_halt = (mq.size() != 0) && (mq[0].w == 32'h0);
                if (e_iv && ir) void'(mq.pop_front());
                if (bv && e_br) begin
                    if (!m_skip) mq.push_back('{lo, bpc, 1'b0});
                    mq.push_back('{hi, bpc + 64'd4, 1'b1});
                    m_skip = 1'b0;
                end
                m_halt = m_halt | new_halt;
            end
            tick();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Decoupling buffer between the AXI instruction-fetch FSM and the decode stage. Accepts 64-bit fetch beats (two packed RV64 instructions plus the PC of the low word) and hands decode one 32-bit instruction per cycle with its PC over a valid/ready handshake. Also handles redirect flushes, a misaligned redirect start, and the all-zero-word halt convention.

## Interface
- `DEPTH`, 8, beat entries stored (power of two, ≥2)
- `ADDR_WIDTH`, 64, PC width
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low reset (asserted at 0)
- `beat_valid`  in  1  fetch beat offered
- `beat_ready`  out  1  queue can accept a beat this cycle
- `beat_data`  in  64  [31:0] instr at `beat_pc`, [63:32] instr at `beat_pc+4`
- `beat_pc`  in  ADDR_WIDTH  8-byte-aligned PC of low word
- `instr_valid`  out  1  head instruction available
- `instr_ready`  in  1  decode consumes head
- `instr`  out  32  head instruction
- `instr_pc`  out  ADDR_WIDTH  PC of head instruction
- `flush`  in  1  redirect: discard all contents
- `flush_pc`  in  ADDR_WIDTH  redirect target (bit 2 significant, bits 1:0 zero)
- `halted`  out  1  sticky: zero instruction reached head
- `level`  out  $clog2(DEPTH)+1  beats stored

## Operation
- Storage: DEPTH entries of {pc, data}; write ptr, read ptr, beat count, 1-bit `half` selector, 1-bit `skip_lo`.
- Enqueue when `beat_valid && beat_ready`; `beat_ready = (count != DEPTH) && !flush && !halted`.
- Head: `instr = half ? data[63:32] : data[31:0]`; `instr_pc = pc + (half ? 4 : 0)`; `instr_valid = (count != 0) && !halted && !flush && instr != 0`.
- Dequeue on `instr_valid && instr_ready`: half=0 → half<=1; half=1 → pop entry, half<=0.
- Misaligned redirect: on `flush` with `flush_pc[2]=1`, `skip_lo<=1`; first beat then written with half start 1 (entry pops after one instruction). `skip_lo` clears when that beat is enqueued.
- Halt: if count≠0 and head `instr==32'h0`, `halted<=1` next edge; head not delivered; `beat_ready=0`. Cleared only by flush or reset.
- Flush: ptrs, count, half cleared; `halted<=0`; simultaneous beat and dequeue ignored (flush wins).
- PC arithmetic modulo 2^ADDR_WIDTH; +4 wraps silently.
- Reset values: `beat_ready=1`, `instr_valid=0`, `instr=0`, `instr_pc=0`, `halted=0`, `level=0`; all pointers/flags zero.

## Timing
- Beat accepted at edge N → `instr_valid=1` from N+1 (registered storage, combinational head read); no bypass.
- Full: `beat_ready=0` when count==DEPTH even if a pop happens same cycle (no ready-on-pop path).
- Simultaneous push and pop at 0<count<DEPTH: count unchanged.
- Steady state: one instruction/cycle out; one beat per two cycles sustains it.
- `halted` rises one cycle after zero word reaches head.
- Reset assertion mid-operation clears state asynchronously; deassertion synchronised externally.

## Configuration
- `FETCH_QUEUE_TRACE_EN` defined: simulation-only `$display("%h: %h", instr_pc, instr)` on every dequeue and "fetch_queue halted at %h" when `halted` rises.
- Undefined: no display statements; RTL identical otherwise.

## Structure
- `fetch_pkg`: `fetch_beat_t` struct {pc, data}, `INSTR_W=32`, `BEAT_W=64`, `INSTR_NOP=32'h00000013`, `INSTR_HALT=32'h0`.
- Sub-module `beat_fifo`: parameterised DEPTH × `fetch_beat_t` circular buffer with ptrs/count, push/pop/clear; `fetch_queue` adds half-select, skip, halt, handshake logic.

## Test plan
- Push beat {pc=0x1000, data=0x00a00593_00000513} with `instr_ready=1` → 0x00000513@0x1000 then 0x00a00593@0x1004 on consecutive cycles, level 1→0.
- Push 8 beats, `instr_ready=0` → `beat_ready=0`, level=8; ninth beat not accepted; 1-cycle pop pulse then still full until entry fully popped.
- `flush` with `flush_pc=0x2004`, then beat pc=0x2000 → first instr_pc=0x2004 (upper word), low word never output.
- Beat {pc=0x3000, data=0x00000000_00008067} → ret@0x3000 delivered, then `halted=1`, `instr_valid=0`, `beat_ready=0`; flush clears halt.
- Flush in same cycle as `beat_valid` and pop with level=3 → next cycle level=0, `instr_valid=0`, beat dropped.
- Drive reset low mid-burst (level=5) → all outputs at reset values immediately, no further dequeues.
